// File: rtl/voq_slot_scheduler_if.sv
// Scheduler bus: VOQ occupancy in, crossgrid control and FIFO read strobes out.
// master = request source / crossbar side, slave = the scheduler.
interface voq_slot_scheduler_if #(
  parameter int number_ports = 4
);
  logic [number_ports*number_ports-1:0] request;
  logic [number_ports*number_ports-1:0] ctr;
  logic [number_ports-1:0]              read_en;
  logic                                 match_valid;
  logic                                 busy;

  modport master (output request, input ctr, input read_en, input match_valid, input busy);
  modport slave  (input request, output ctr, output read_en, output match_valid, output busy);
endinterface

// File: rtl/voq_slot_scheduler.sv
// Slot-based iSLIP scheduler for an NxN crossbar.
// Snapshots VOQ occupancy, runs up to ITERATIONS request/grant/accept rounds with
// round-robin pointers, then holds the crossgrid word for CELL_CYCLES cycles and
// pulses the read enable of every matched input FIFO once.
// Optional build macro SCHED_STATS_EN adds a saturating match_count output.
module voq_slot_scheduler #(
  parameter int number_ports = 4,
  parameter int ITERATIONS   = 2,
  parameter int CELL_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  voq_slot_scheduler_if.slave   sif
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]           match_count
`endif
);

  localparam int N  = number_ports;
  localparam int NN = N * N;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(CELL_CYCLES + 1);
  localparam logic [4:0]    ITER_LAST = 5'(ITERATIONS - 1);
  localparam logic [CW-1:0] CC_LAST   = CW'(CELL_CYCLES);

  typedef enum logic [1:0] {IDLE, GRANT, ACCEPT, XFER} state_t;

  state_t          state_q, state_d;
  logic [NN-1:0]   snap_q, gnt_q, gnt_d, acc_d;
  logic [NN-1:0]   match_q, match_d, first_q, first_d;
  logic [NN-1:0]   ctr_q, ctr_d;
  logic [N-1:0]    rd_q, rd_d, row_m, col_m;
  logic            mv_q, mv_d, busy_q, xfer_go;
  logic [4:0]      iter_q, iter_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   gptr_q [N];
  logic [PW-1:0]   gptr_d [N];
  logic [PW-1:0]   aptr_q [N];
  logic [PW-1:0]   aptr_d [N];

  // Round-robin distance of idx from pointer ptr (0 = highest priority).
  function automatic int rot_dist(input int idx, input logic [PW-1:0] ptr);
    int p;
    p = int'(ptr);
    return (idx >= p) ? (idx - p) : (idx + N - p);
  endfunction

`ifdef SCHED_STATS_EN
  function automatic int popcount(input logic [NN-1:0] v);
    int c;
    c = 0;
    for (int k = 0; k < NN; k++) c += int'(v[k]);
    return c;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input int b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
`endif

  // Which inputs (rows) and outputs (columns) are already in the match set.
  always_comb begin
    row_m = '0;
    col_m = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (match_q[i*N+j]) begin
          row_m[i] = 1'b1;
          col_m[j] = 1'b1;
        end
  end

  // Grant: each free output picks the nearest free requesting input from its pointer.
  always_comb begin
    int best, win;
    gnt_d = '0;
    for (int j = 0; j < N; j++) begin
      best = N;
      win  = 0;
      for (int i = 0; i < N; i++)
        if (snap_q[i*N+j] && !row_m[i] && !col_m[j] && rot_dist(i, gptr_q[j]) < best) begin
          best = rot_dist(i, gptr_q[j]);
          win  = i;
        end
      for (int i = 0; i < N; i++)
        if (best < N && win == i) gnt_d[i*N+j] = 1'b1;
    end
  end

  // Accept: each free input picks the nearest granting output from its pointer.
  always_comb begin
    int best, win;
    acc_d = '0;
    for (int i = 0; i < N; i++) begin
      best = N;
      win  = 0;
      for (int j = 0; j < N; j++)
        if (gnt_q[i*N+j] && !row_m[i] && rot_dist(j, aptr_q[i]) < best) begin
          best = rot_dist(j, aptr_q[i]);
          win  = j;
        end
      for (int j = 0; j < N; j++)
        if (best < N && win == j) acc_d[i*N+j] = 1'b1;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    logic [N-1:0] cols_all;
    state_d  = state_q;
    match_d  = match_q;
    first_d  = first_q;
    iter_d   = iter_q;
    cnt_d    = cnt_q;
    ctr_d    = ctr_q;
    rd_d     = '0;
    mv_d     = mv_q;
    xfer_go  = 1'b0;
    cols_all = col_m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (acc_d[i*N+j]) cols_all[j] = 1'b1;
    case (state_q)
      IDLE: begin
        if (|sif.request) begin
          state_d = GRANT;
          match_d = '0;
          first_d = '0;
          iter_d  = '0;
        end
      end
      GRANT: state_d = ACCEPT;
      ACCEPT: begin
        match_d = match_q | acc_d;
        if (iter_q == '0) first_d = acc_d;
        if (iter_q == ITER_LAST || acc_d == '0 || &cols_all) begin
          state_d = XFER;
          cnt_d   = '0;
          xfer_go = 1'b1;
        end else begin
          iter_d  = iter_q + 5'd1;
          state_d = GRANT;
        end
      end
      XFER: begin
        if (cnt_q == '0) begin
          ctr_d = match_q;
          rd_d  = row_m;
          mv_d  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end else if (cnt_q == CC_LAST) begin
          ctr_d   = '0;
          mv_d    = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // iSLIP pointer advance from first-iteration matches only.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      gptr_d[k] = gptr_q[k];
      aptr_d[k] = aptr_q[k];
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (first_d[i*N+j]) begin
          gptr_d[j] = PW'((i + 1) % N);
          aptr_d[i] = PW'((j + 1) % N);
        end
  end

  // Control state, match set, pointers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      match_q <= '0;
      first_q <= '0;
      iter_q  <= '0;
      cnt_q   <= '0;
      ctr_q   <= '0;
      rd_q    <= '0;
      mv_q    <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        gptr_q[k] <= '0;
        aptr_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      first_q <= first_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      ctr_q   <= ctr_d;
      rd_q    <= rd_d;
      mv_q    <= mv_d;
      busy_q  <= (state_d != IDLE);
      if (xfer_go)
        for (int k = 0; k < N; k++) begin
          gptr_q[k] <= gptr_d[k];
          aptr_q[k] <= aptr_d[k];
        end
    end
  end

  // Occupancy snapshot and grant register; only meaningful once a slot is running.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) snap_q <= sif.request;
    gnt_q <= gnt_d;
  end

`ifdef SCHED_STATS_EN
  // Saturating count of cells matched across all slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        match_count <= '0;
    else if (xfer_go) match_count <= sat_add(match_count, popcount(match_d));
  end
`endif

  assign sif.ctr         = ctr_q;
  assign sif.read_en     = rd_q;
  assign sif.match_valid = mv_q;
  assign sif.busy        = busy_q;

endmodule

// File: tb/tb_voq_slot_scheduler.sv
// Directed bench for voq_slot_scheduler (N=4, ITERATIONS=2, CELL_CYCLES=2).
module tb_voq_slot_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  voq_slot_scheduler_if #(.number_ports(4)) bus ();

`ifdef SCHED_STATS_EN
  logic [15:0] match_count;
`endif

  voq_slot_scheduler #(.number_ports(4), .ITERATIONS(2), .CELL_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (bus)
`ifdef SCHED_STATS_EN
    ,
    .match_count (match_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic [15:0] noise;
    logic [15:0] ctr;
    logic [3:0]  rd;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", nm, what, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.request = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.request = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drive req for the snapshot edge, noise afterwards, then check the XFER phase.
  task automatic run_slot(input string nm, input logic [15:0] req, input logic [15:0] noise,
                          input logic [15:0] ectr, input logic [3:0] erd, input int lat);
    int n;
    n = 1;
    bus.request = req;
    @(posedge clk);
    #1;
    bus.request = noise;
    while (bus.read_en == '0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.request = '0;
    check(nm, "latency", n, lat + 1);
    check(nm, "ctr", bus.ctr, ectr);
    check(nm, "read_en", bus.read_en, erd);
    check(nm, "match_valid", bus.match_valid, 1);
    check(nm, "busy", bus.busy, 1);
    @(posedge clk);
    #1;
    check(nm, "read_en_pulse", bus.read_en, 0);
    check(nm, "ctr_hold", bus.ctr, ectr);
    check(nm, "mv_hold", bus.match_valid, 1);
    @(posedge clk);
    #1;
    check(nm, "mv_end", bus.match_valid, 0);
    check(nm, "ctr_end", bus.ctr, 0);
    check(nm, "busy_end", bus.busy, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{req: 16'h0001, noise: 16'hFFFF, ctr: 16'h0001, rd: 4'b0001, lat: 5};
    vecs[1] = '{req: 16'h0D77, noise: 16'h0000, ctr: 16'h0821, rd: 4'b0111, lat: 5};
    vecs[2] = '{req: 16'hFFFF, noise: 16'h0000, ctr: 16'h0021, rd: 4'b0011, lat: 5};
    vecs[3] = '{req: 16'h8421, noise: 16'h0001, ctr: 16'h8421, rd: 4'b1111, lat: 3};
    vecs[4] = '{req: 16'h1248, noise: 16'h0000, ctr: 16'h1248, rd: 4'b1111, lat: 3};
    vecs[5] = '{req: 16'h000F, noise: 16'h0000, ctr: 16'h0001, rd: 4'b0001, lat: 5};
    vecs[6] = '{req: 16'h1111, noise: 16'h00F0, ctr: 16'h0001, rd: 4'b0001, lat: 5};
    vecs[7] = '{req: 16'h00F0, noise: 16'h0000, ctr: 16'h0010, rd: 4'b0010, lat: 5};
    vecs[8] = '{req: 16'hF000, noise: 16'h0000, ctr: 16'h1000, rd: 4'b1000, lat: 5};

    bus.request = 16'hFFFF;
    // Reset state with every VOQ occupied.
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", "ctr", bus.ctr, 0);
    check("reset", "read_en", bus.read_en, 0);
    check("reset", "match_valid", bus.match_valid, 0);
    check("reset", "busy", bus.busy, 0);
    for (int k = 0; k < 4; k++) begin
      check("reset", "grant_ptr", dut.gptr_q[k], 0);
      check("reset", "accept_ptr", dut.aptr_q[k], 0);
    end
    bus.request = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Empty request in IDLE stays quiet.
    repeat (4) @(posedge clk);
    #1;
    check("idle", "busy", bus.busy, 0);
    check("idle", "ctr", bus.ctr, 0);

    // Table of single slots from fresh pointers.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      run_slot($sformatf("vec%0d", v), vecs[v].req, vecs[v].noise, vecs[v].ctr, vecs[v].rd, vecs[v].lat);
    end

    // Pointers after the 0x0D77 slot.
    do_reset();
    run_slot("ptr", 16'h0D77, 16'h0000, 16'h0821, 4'b0111, 5);
    check("ptr", "grant_ptr0", dut.gptr_q[0], 1);
    check("ptr", "grant_ptr1", dut.gptr_q[1], 0);
    check("ptr", "grant_ptr2", dut.gptr_q[2], 0);
    check("ptr", "grant_ptr3", dut.gptr_q[3], 3);
    check("ptr", "accept_ptr0", dut.aptr_q[0], 1);
    check("ptr", "accept_ptr1", dut.aptr_q[1], 0);
    check("ptr", "accept_ptr2", dut.aptr_q[2], 0);
    check("ptr", "accept_ptr3", dut.aptr_q[3], 0);

    // Two back-to-back slots sharing output 0: the grant pointer rotates.
    do_reset();
    run_slot("rr1", 16'h0011, 16'h0011, 16'h0001, 4'b0001, 5);
    check("rr1", "grant_ptr0", dut.gptr_q[0], 1);
    run_slot("rr2", 16'h0011, 16'h0000, 16'h0010, 4'b0010, 5);

    // Reset in the middle of XFER drops everything at once.
    do_reset();
    bus.request = 16'h0D77;
    @(posedge clk);
    #1;
    bus.request = '0;
    n = 1;
    while (bus.read_en == '0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midrst", "reached_xfer", n, 6);
    reset = 1'b1;
    #1;
    check("midrst", "ctr", bus.ctr, 0);
    check("midrst", "read_en", bus.read_en, 0);
    check("midrst", "match_valid", bus.match_valid, 0);
    check("midrst", "busy", bus.busy, 0);
    check("midrst", "grant_ptr0", dut.gptr_q[0], 0);
    check("midrst", "grant_ptr3", dut.gptr_q[3], 0);
    check("midrst", "accept_ptr0", dut.aptr_q[0], 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_slot("after_rst", 16'h0D77, 16'h0000, 16'h0821, 4'b0111, 5);

`ifdef SCHED_STATS_EN
    do_reset();
    check("stats", "cleared", match_count, 0);
    run_slot("stats1", 16'h0001, 16'h0000, 16'h0001, 4'b0001, 5);
    check("stats", "count1", match_count, 1);
    bus.request = 16'h0D77;
    @(posedge clk);
    #1;
    bus.request = '0;
    repeat (8) @(posedge clk);
    #1;
    check("stats", "count4", match_count, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
